simm_arbiter: RTL
=================

// Module: simm_arbiter
// PURPOSE
// - Shares one simm_16mb DRAM controller between NREQ requesters, e.g. video scanout
//   and CPU, using round-robin arbitration.
// - Captures the granted request and drives the controller's ena/addr/write handshake.
// - Rides out refresh cycles, returns read data, and pulses a per-port done.
// - Sits between the requester blocks and the SIMM controller; owns the DQ write-drive enable.
// PARAMETERS
// - NREQ   default 2    number of requesters, 2..8
// - AW     default 24   address width, matching the controller's addr
// - DW     default 8    data width, matching the controller's rd_data
// PORTS
// - clk          in   1        system clock, the only clock
// - rst_n        in   1        asynchronous reset, active-low
// - req          in   NREQ     per-port request, level
// - req_we       in   NREQ     per-port write (1) or read (0)
// - req_addr     in   NREQ*AW  per-port address; port i is bits [i*AW +: AW]
// - req_wdata    in   NREQ*DW  per-port write data; port i is bits [i*DW +: DW]
// - done         out  NREQ     one-cycle completion pulse for the granted port
// - rdata        out  DW       read data; valid in the done cycle, held until the next read completes
// - gnt_id       out  3        index of the current/last granted port
// - mem_ena      out  1        to controller ena
// - mem_write    out  1        to controller write
// - mem_addr     out  AW       to controller addr
// - mem_wdata    out  DW       write data toward the DQ tristate
// - mem_wdata_oe out  1        drive enable for the DQ tristate
// - mem_busy     in   1        from controller busy (high when not IDLE)
// - mem_ack      in   1        from controller ack
// - mem_rd_data  in   DW       from controller rd_data
// BEHAVIOUR
// - Reset values (async, rst_n=0):
//   - state=IDLE; mem_ena, mem_write, mem_wdata_oe = 0; done = 0.
//   - rdata = 0, mem_addr = 0, mem_wdata = 0, gnt_id = 0.
//   - RR pointer = 0, so port 0 has highest priority first.
// - All outputs are registered. Requester must hold req until done.
// - Request fields are sampled only at grant. After grant, changes to req, addr,
//   we or wdata do not affect the transaction; done still pulses.
// - FSM:
//   - IDLE:
//     - If any req: pick the first asserted port starting at the RR pointer,
//       wrapping NREQ-1 -> 0.
//     - Latch addr, we and wdata into mem_*; set gnt_id; mem_ena <= 1.
//     - mem_wdata_oe <= we. Go to ISSUE.
//   - ISSUE:
//     - Hold mem_ena and all mem_* stable.
//     - Accept is detected when mem_busy && mem_ack. Then mem_ena <= 0; go to WAIT.
//     - mem_busy && !mem_ack means refresh or init is in progress: keep mem_ena, stay in ISSUE.
//     - mem_busy=0 means the controller has not sampled ena yet: stay in ISSUE.
//   - WAIT:
//     - Stay while mem_busy=1.
//     - On mem_busy=0: if read, rdata <= mem_rd_data. done[gnt_id] <= 1 for one cycle.
//     - mem_wdata_oe <= 0. RR pointer <= gnt_id+1 (mod NREQ). Go to IDLE.
// - A single request costs at least one IDLE cycle between transactions.
//   A port re-requesting immediately loses to any other waiting port.
// - Latency, IDLE with req at edge 0:
//   - mem_ena high after edge 1.
//   - mem_busy & mem_ack seen at edge 2; mem_ena low after edge 2.
//   - done is the cycle after busy is first seen low.
// - mem_ack may still be high in the controller's first IDLE cycle.
//   Accept is only recognised with mem_busy=1, so a stale ack is ignored.
// - Controller busy at reset release (INIT/refresh): the first request waits in ISSUE.
//   No timeout.
// - Reset mid-transaction: the arbiter returns to IDLE, the controller finishes on its own,
//   and the next grant waits in ISSUE until busy falls then rises with ack. No done is issued
//   for the aborted transaction.
// - Simultaneous req on all ports: exactly one grant per transaction; fair rotation
//   with no starvation.
// - done is one-hot or zero.
// TESTING
// - Single read, port 0 addr=24'h123456, model returns 8'hA5:
//   - mem_ena after 1 clk; rdata=A5 with done=01; mem_wdata_oe stays 0.
// - Write, port 1 addr=24'h000FFF, wdata=8'h3C:
//   - mem_write=1 and mem_wdata_oe=1 from grant until done;
//   - the model sees exactly one write of 3C to FFF.
// - Both ports request continuously for 6 transactions:
//   - grant order 0,1,0,1,0,1; each done is a single-cycle pulse.
// - Refresh collision: the model holds busy=1, ack=0 for 10 clk after ena:
//   - mem_ena is held through it; the transaction completes after refresh; one done.
// - Stale ack: the model keeps ack=1 for one cycle after busy falls and a new req is pending:
//   - no false accept; mem_ena stays until busy=1 and ack=1.
// - Assert rst_n=0 mid-WAIT, release after 3 clk:
//   - all outputs are at reset values; no done; the next request completes normally.

Source files
------------

// File: rtl/simm_arbiter.sv
// Round-robin arbiter sharing one SIMM DRAM controller among NREQ requesters.
// Latches the winning request at grant and runs the controller's ena/busy/ack handshake.
module simm_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 24,
  parameter int DW   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic [NREQ-1:0]      done,
  output logic [DW-1:0]        rdata,
  output logic [2:0]           gnt_id,
  output logic                 mem_ena,
  output logic                 mem_write,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  output logic                 mem_wdata_oe,
  input  logic                 mem_busy,
  input  logic                 mem_ack,
  input  logic [DW-1:0]        mem_rd_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t          state_q, state_d;
  logic [2:0]      rr_q, rr_d;
  logic [2:0]      gnt_q, gnt_d;
  logic            ena_q, ena_d;
  logic            write_q, write_d;
  logic            oe_q, oe_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [NREQ-1:0] done_q, done_d;

  logic            any_req;
  logic [2:0]      pick;

  // First asserted port at or after the pointer, wrapping NREQ-1 -> 0.
  always_comb begin
    any_req = 1'b0;
    pick    = 3'd0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!any_req && req[i] && (((int'(rr_q) + k) % NREQ) == i)) begin
          any_req = 1'b1;
          pick    = 3'(i);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    ena_d   = ena_q;
    write_d = write_q;
    oe_d    = oe_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    done_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d   = pick;
          ena_d   = 1'b1;
          state_d = ISSUE;
          for (int i = 0; i < NREQ; i++) begin
            if (pick == 3'(i)) begin
              write_d = req_we[i];
              oe_d    = req_we[i];
              addr_d  = req_addr[i*AW +: AW];
              wdata_d = req_wdata[i*DW +: DW];
            end
          end
        end
      end
      ISSUE: begin
        // An ack without busy is left over from the previous cycle; ignore it.
        if (mem_busy && mem_ack) begin
          ena_d   = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!mem_busy) begin
          if (!write_q) begin
            rdata_d = mem_rd_data;
          end
          for (int i = 0; i < NREQ; i++) begin
            if (gnt_q == 3'(i)) begin
              done_d[i] = 1'b1;
            end
          end
          oe_d    = 1'b0;
          rr_d    = (gnt_q == 3'(NREQ - 1)) ? 3'd0 : gnt_q + 3'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= 3'd0;
      gnt_q   <= 3'd0;
      ena_q   <= 1'b0;
      write_q <= 1'b0;
      oe_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      ena_q   <= ena_d;
      write_q <= write_d;
      oe_q    <= oe_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
    end
  end

  assign done         = done_q;
  assign rdata        = rdata_q;
  assign gnt_id       = gnt_q;
  assign mem_ena      = ena_q;
  assign mem_write    = write_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_wdata_oe = oe_q;

endmodule
